// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer built around a single full-adder cell.
// Operands come in and results go out over valid/ready handshakes; LSB is processed first.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for an operand set (in_ready)
  // RUN   | one result bit per edge through the adder cell (busy)
  // DONE  | result held until the consumer takes it (out_valid)
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;

  assign fa_s  = sh_a[0] ^ sh_b[0] ^ carry;
  assign fa_co = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
  end

  // Subtract is A + ~B + 1: B is inverted on load and the carry seeds the +1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sum   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= a;
            sh_b  <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout <= fa_co;
            ovf  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, corner-case
// sequences and random operands compared against an integer-arithmetic model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[5];
  vec_t q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    vec_t r;
    int ua, ub, raw, sa, sb, sr;
    ua = int'(va);
    ub = int'(vb);
    sa = int'($signed(va));
    sb = int'($signed(vb));
    raw = vs ? ua - ub : ua + ub;
    sr  = vs ? sa - sb : sa + sb;
    r.a   = va;
    r.b   = vb;
    r.sub = vs;
    r.s   = raw[W-1:0];
    r.co  = vs ? (ua >= ub) : (raw > (1 << W) - 1);
    r.ov  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    int n;
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    sub = v.sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    chk("run_busy", busy, 1);
    chk("run_out_valid", out_valid, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, W);
    chk("sum", sum, v.s);
    chk("cout", cout, v.co);
    chk("ovf", ovf, v.ov);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    vec_t e;
    int   got, k, cyc, last_acc;
    bit   acc;

    tbl[0] = '{a: 8'd100, b: 8'd27, sub: 1'b0, s: 8'd127, co: 1'b0, ov: 1'b0};
    tbl[1] = '{a: 8'hC8,  b: 8'h64, sub: 1'b0, s: 8'h2C,  co: 1'b1, ov: 1'b0};
    tbl[2] = '{a: 8'h7F,  b: 8'h01, sub: 1'b0, s: 8'h80,  co: 1'b0, ov: 1'b1};
    tbl[3] = '{a: 8'd5,   b: 8'd7,  sub: 1'b1, s: 8'hFE,  co: 1'b0, ov: 1'b0};
    tbl[4] = '{a: 8'h80,  b: 8'h01, sub: 1'b1, s: 8'h7F,  co: 1'b1, ov: 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);

    for (int i = 0; i < 5; i++) run_op(tbl[i]);

    for (int i = 0; i < 20; i++)
      run_op(model(W'($urandom), W'($urandom), 1'($urandom)));

    // Backpressure, with noise on the operand inputs during RUN and DONE.
    e = model(8'h3C, 8'h19, 1'b0);
    in_valid = 1'b1; a = e.a; b = e.b; sub = e.sub;
    @(posedge clk); #1;
    for (int i = 0; i < W; i++) begin
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      chk("bp_run_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_sum", sum, e.s);
      chk("bp_hold_cout", cout, e.co);
      chk("bp_hold_ovf", ovf, e.ov);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_no_accept_at_handoff", busy, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset at the 4th RUN edge throws the partial result away.
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    run_op(model(8'd3, 8'd4, 1'b0));

    // Back-to-back with both handshakes held high.
    got = 0; k = 0; cyc = 0; last_acc = 0;
    e = model(W'($urandom), W'($urandom), 1'($urandom));
    a = e.a; b = e.b; sub = e.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 10 && cyc < 400) begin
      acc = 1'b0;
      if (in_ready && in_valid) begin
        q.push_back(model(a, b, sub));
        if (k > 0) chk("issue_interval", cyc - last_acc, W + 2);
        last_acc = cyc;
        k++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (k < 10) begin
          a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_spurious_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("b2b_sum", sum, e.s);
          chk("b2b_cout", cout, e.co);
          chk("b2b_ovf", ovf, e.ov);
        end
        got++;
      end
    end
    if (got < 10) chk("b2b_results", got, 10);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that time-shares one 1-bit full-adder cell (inputs a, b, c; outputs cout, s) to perform WIDTH-bit add or subtract, bit-serially, LSB first.
- Operands arrive through a valid/ready handshake, and the result leaves through a valid/ready handshake.
- Sits between an operand source and a result consumer where area matters more than throughput.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- sub  input  1  0: A+B; 1: A−B; sampled with operands
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result bits
- cout  output  1  carry out of MSB; for subtract, 1 means no borrow
- ovf  output  1  signed overflow
- busy  output  1  high while in RUN

Behaviour:
- Interface:
  - One clock (clk).
  - Reset rst is synchronous and active-high.
  - No asynchronous reset anywhere.
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0.
  - Bit counter=0, carry register=0.
  - rst has priority over every other event, including mid-RUN and in DONE. A partial result is discarded and never presented.
- FSM states: IDLE, RUN, DONE. Exactly one is active.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the operands are accepted:
    - a goes into shift register A.
    - b XOR {WIDTH{sub}} goes into shift register B.
    - The carry register loads sub (carry-in = 1 for subtract).
    - The bit counter loads 0.
    - State → RUN.
  - With in_valid=0, the state holds.
- RUN (busy=1, in_ready=0; a/b/sub are ignored):
  - On each edge, the adder cell computes the LSB of A, the LSB of B, and the carry register.
  - The cell's s output shifts into the MSB of the sum shift register (right shift).
  - A and B shift right.
  - The carry register takes cout.
  - The counter increments.
  - On the edge where counter = WIDTH−1:
    - ovf is set to (carry into MSB) XOR (carry out of MSB), where carry into MSB is the carry register's value before that edge.
    - cout takes the final carry.
    - State → DONE.
- Latency:
  - Accept at edge E0.
  - Bits are processed at edges E1..E_WIDTH.
  - out_valid=1 from the cycle after E_WIDTH.
  - Accept-to-result is WIDTH edges. Minimum issue interval is WIDTH+2 cycles.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - in_ready=0.
  - On an edge with out_ready=1: out_valid→0, state → IDLE.
  - Result registers keep their last value after the handoff. Consumers must qualify them with out_valid.
  - With out_ready=0, the state holds indefinitely (backpressure) and the result is unchanged.
- Simultaneous events:
  - in_valid is never accepted in the same cycle as a DONE handoff; the new accept occurs no earlier than the next IDLE cycle.
  - out_ready in IDLE or RUN has no effect.
- Arithmetic:
  - sum = (a + (sub ? ~b+1 : b)) mod 2^WIDTH.
  - Widths are exact; there is no sign extension.
- Output decoding:
  - in_ready = (state==IDLE).
  - busy = (state==RUN).
  - out_valid = (state==DONE).
  - All three are decoded only from registered state.

Test Plan:
- Run all scenarios with WIDTH=8.
- Reset, then add: hold rst 2 cycles → in_ready=1, out_valid=0, sum=0. Then a=100, b=27, sub=0 → after 8 edges, out_valid=1, sum=127, cout=0, ovf=0.
- Unsigned carry: a=0xC8, b=0x64, sub=0 → sum=0x2C, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1 → sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- Backpressure and ignore: keep out_ready=0 for 5 cycles in DONE → out_valid, sum, cout and ovf are all stable. Toggle in_valid with different a/b during RUN and DONE → result is unaffected and in_ready=0. Raise out_ready → out_valid falls at the next edge, and in_ready=1 in the following cycle.
- Reset mid-operation: accept a=0xFF, b=0x01, assert rst at the 4th RUN edge → next cycle is IDLE with out_valid=0 and sum=0. A following 3+4 returns sum=7 with no residue from the aborted op.
- Back-to-back throughput: in_valid and out_ready tied to 1, 10 random operand pairs → each result matches the reference model, and accepts are spaced exactly WIDTH+2 cycles apart.
